// File: rtl/unsigned_trunc_div_16by8_l2_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : approx_arith_pkg
//  Purpose   : Shared types and constants for the approximate arithmetic
//              datapath (truncated multipliers / truncated divider).
//  Revision  : 1.0 - initial release
// ============================================================================
package approx_arith_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Remainder reported when the divisor is zero.
  localparam logic [7:0] DIV0_R = 8'hFF;

  // Iteration counter width: it must be able to hold 16 (L = 0).
  localparam int CNT_W = $clog2(17);

  // Number of restoring iterations once L dividend LSBs are dropped.
  function automatic int iter_of(input int l);
    return 16 - l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unsigned_trunc_div_16by8_l2_trunc_div_step.sv
`default_nettype none
// ============================================================================
//  Module    : trunc_div_step
//  Purpose   : One combinational restoring-division step. Shifts the next
//              dividend bit into the partial remainder and subtracts the
//              divisor when it fits.
//  Revision  : 1.0 - initial release
// ============================================================================
module trunc_div_step
  import approx_arith_pkg::*;
(
  input  logic [8:0] rem_in,
  input  logic       bit_in,
  input  logic [7:0] dv,
  output logic [8:0] rem_out,
  output logic       qbit
);

  logic [8:0] w_t;
  logic       w_unused_msb;

  // The incoming remainder is always below the divisor, so its MSB is zero.
  assign w_unused_msb = rem_in[8];

  // Trial subtraction: keep the difference when the divisor fits.
  always_comb begin
    w_t = {rem_in[7:0], bit_in};
    if (w_t >= {1'b0, dv}) begin
      rem_out = w_t - {1'b0, dv};
      qbit    = 1'b1;
    end else begin
      rem_out = w_t;
      qbit    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/unsigned_trunc_div_16by8_l2.sv
`default_nettype none
// ============================================================================
//  Module    : unsigned_trunc_div_16by8_l2
//  Purpose   : Iterative approximate unsigned divider. Drops the low L
//              dividend bits, then runs one restoring step per clock.
//              z_q = ((x>>L)/y)<<L, z_r = (x>>L)%y. Valid/ready on both sides.
//  Revision  : 1.0 - initial release
// ============================================================================
module unsigned_trunc_div_16by8_l2
  import approx_arith_pkg::*;
#(
  parameter int          L      = 2,
  parameter logic [15:0] DIV0_Q = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] z_q,
  output logic [7:0]  z_r,
  output logic        div0
);

  localparam int               ITER     = iter_of(L);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  div_state_t        state_q, state_d;
  logic [ITER-1:0]   dd_q, dd_d;
  logic [ITER-1:0]   quo_q, quo_d;
  logic [7:0]        dv_q, dv_d;
  logic [8:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       zq_q, zq_d;
  logic [7:0]        zr_q, zr_d;
  logic              div0_q, div0_d;

  logic [8:0]        w_rem_step;
  logic              w_qbit;
  logic [ITER-1:0]   w_quo_shift;
  logic              w_unused_x;

  // The dropped dividend LSBs never reach the datapath.
  assign w_unused_x = ^x;

  trunc_div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (dd_q[ITER-1]),
    .dv      (dv_q),
    .rem_out (w_rem_step),
    .qbit    (w_qbit)
  );

  assign w_quo_shift = {quo_q[ITER-2:0], w_qbit};

  // Next-state and datapath updates for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d = state_q;
    dd_d    = dd_q;
    quo_d   = quo_q;
    dv_d    = dv_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zq_d    = zq_q;
    zr_d    = zr_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dd_d  = x[15:L];
          dv_d  = y;
          rem_d = '0;
          cnt_d = '0;
          quo_d = '0;
          if (y == 8'd0) begin
            // Divide-by-zero skips the iterations entirely.
            state_d = DONE;
            zq_d    = DIV0_Q;
            zr_d    = DIV0_R;
            div0_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = w_rem_step;
        quo_d = w_quo_shift;
        dd_d  = dd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          zq_d    = 16'(w_quo_shift) << L;
          zr_d    = w_rem_step[7:0];
          div0_d  = 1'b0;
        end
      end
      DONE: begin
        // Result stays put until the consumer takes it.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dd_q    <= '0;
      quo_q   <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zq_q    <= '0;
      zr_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dd_q    <= dd_d;
      quo_q   <= quo_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zq_q    <= zq_d;
      zr_q    <= zr_d;
      div0_q  <= div0_d;
    end
  end

  // Handshake flags come straight from the state register, so out_ready
  // has no combinational route to in_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z_q       = zq_q;
  assign z_r       = zr_q;
  assign div0      = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_trunc_div_16by8_l2.sv
`default_nettype none
// ============================================================================
//  Module    : tb_unsigned_trunc_div_16by8_l2
//  Purpose   : Self-checking bench for the truncated 16/8 divider (L = 2).
//              Expected results are queued at issue time and checked by an
//              independent monitor whenever a result is handed off.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_unsigned_trunc_div_16by8_l2;

  localparam int L = 2;

  typedef struct packed {
    logic [15:0] zq;
    logic [7:0]  zr;
    logic        div0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z_q;
  logic [7:0]  z_r;
  logic        div0;

  exp_t sb[$];
  int   rise_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic ov_prev = 1'b0;
  logic rnd = 1'b0;

  unsigned_trunc_div_16by8_l2 #(.L(L), .DIV0_Q(16'hFFFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_q       (z_q),
    .z_r       (z_r),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the truncated dividend.
  function automatic exp_t model(input logic [15:0] xv, input logic [7:0] yv);
    exp_t e;
    int   dd;
    if (yv == 8'd0) begin
      e.zq   = 16'hFFFF;
      e.zr   = 8'hFF;
      e.div0 = 1'b1;
    end else begin
      dd     = int'(xv) / (1 << L);
      e.zq   = 16'((dd / int'(yv)) * (1 << L));
      e.zr   = 8'(dd % int'(yv));
      e.div0 = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation; the expected result is queued once it is accepted.
  task automatic issue(input logic [15:0] xv, input logic [7:0] yv);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("in_ready wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(xv, yv));
  endtask

  // Count cycles after the accepting edge until out_valid shows.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain queue empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Monitor: every handed-off result is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) rise_q.push_back(cyc);
    ov_prev <= out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected result: got z_q=%0h z_r=%0h div0=%0b with nothing pending", z_q, z_r, div0);
      end else begin
        e = sb.pop_front();
        chk("sb z_q", 32'(z_q), 32'(e.zq));
        chk("sb z_r", 32'(z_r), 32'(e.zr));
        chk("sb div0", 32'(div0), 32'(e.div0));
      end
    end
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] sq;
    logic [7:0]  sr;
    logic [15:0] rx;
    logic [7:0]  ry;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst z_q", 32'(z_q), 32'd0);
    chk("rst z_r", 32'(z_r), 32'd0);
    chk("rst div0", 32'(div0), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1000 / 7 with two dropped LSBs.
    issue(16'd1000, 8'd7);
    wait_valid(lat);
    chk("lat 1000/7", 32'(lat), 32'd14);
    chk("z_q 1000/7", 32'(z_q), 32'd140);
    chk("z_r 1000/7", 32'(z_r), 32'd5);
    tick();

    // Divisor of one keeps everything but the dropped bits.
    issue(16'd65535, 8'd1);
    wait_valid(lat);
    chk("z_q 65535/1", 32'(z_q), 32'd65532);
    chk("z_r 65535/1", 32'(z_r), 32'd0);
    tick();

    // Consumer stalls 5 cycles; dividend below 2^L gives zero.
    out_ready = 1'b0;
    issue(16'd3, 8'd9);
    wait_valid(lat);
    sq = z_q;
    sr = z_r;
    chk("z_q 3/9", 32'(z_q), 32'd0);
    chk("z_r 3/9", 32'(z_r), 32'd0);
    repeat (5) begin
      tick();
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall z_q", 32'(z_q), 32'(sq));
      chk("stall z_r", 32'(z_r), 32'(sr));
    end
    out_ready = 1'b1;
    tick();
    chk("handoff in_ready", 32'(in_ready), 32'd1);

    // Divide by zero: result visible right after the accepting edge, held.
    out_ready = 1'b0;
    issue(16'd1234, 8'd0);
    chk("div0 out_valid", 32'(out_valid), 32'd1);
    chk("div0 z_q", 32'(z_q), 32'hFFFF);
    chk("div0 z_r", 32'(z_r), 32'hFF);
    chk("div0 flag", 32'(div0), 32'd1);
    repeat (2) tick();
    chk("div0 hold", 32'(out_valid), 32'd1);
    chk("div0 hold flag", 32'(div0), 32'd1);
    out_ready = 1'b1;
    tick();

    // An in_valid pulse while busy must be ignored.
    issue(16'd1000, 8'd7);
    repeat (3) tick();
    in_valid = 1'b1;
    x        = 16'd5;
    y        = 8'd1;
    chk("busy in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("busy ignore z_q", 32'(z_q), 32'd140);
    chk("busy ignore div0", 32'(div0), 32'd0);
    tick();
    chk("after ignore out_valid", 32'(out_valid), 32'd0);

    // Back-to-back with the consumer always ready.
    rise_q.delete();
    issue(16'd40000, 8'd200);
    issue(16'd512, 8'd255);
    drain();
    chk("b2b rise count", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() == 2) chk("b2b spacing", 32'(rise_q[1] - rise_q[0]), 32'd16);

    // Reset in the middle of an iteration discards the pending result.
    issue(16'd1000, 8'd7);
    repeat (6) tick();
    chk("pre-reset busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    sb.delete();
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort z_q", 32'(z_q), 32'd0);
    chk("abort z_r", 32'(z_r), 32'd0);
    rst_n = 1'b1;
    tick();
    issue(16'd1000, 8'd7);
    wait_valid(lat);
    chk("post-reset z_q", 32'(z_q), 32'd140);
    chk("post-reset z_r", 32'(z_r), 32'd5);
    tick();

    // Random operands with a randomly stalling consumer.
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 16'($urandom_range(0, 7));
      ry = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      issue(rx, ry);
      out_ready = 1'($urandom_range(0, 1));
    end
    rnd = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
